spike_encoder: RTL and testbench
================================

# spike_encoder

Upstream stage of the temporal comparators. It converts a vector of binary values into race-logic spike times within a repeating gamma cycle, and generates the gamma-cycle `set` pulse that re-arms downstream comparator latches. Channel `i` fires at phase equal to its value, as a fixed-width pulse or as a held rising edge. The encoder's `spike_o` and `set_o` drive the comparators' `a`/`b` and `set` inputs directly.

## Interface
- `GAMMA_CYCLE_WIDTH`, 16: cycles per gamma cycle (G); must be ≥ 2.
- `PULSE_WIDTH`, 8: spike length in cycles (P); must be ≥ 1 and ≤ G.
- `NUM_CH`, 2: number of encoded channels.
- `VW` (derived, not overridable) = $clog2(G)+1: value width per channel.
- `aclk`  in  1  clock; all state changes on its rising edge.
- `grst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  the `in_value` vector is presented.
- `in_ready`  out  1  pending buffer empty; transfer occurs when `in_valid && in_ready` at a clock edge.
- `in_value`  in  NUM_CH*VW  channel `i` occupies bits [i*VW +: VW]. Any value ≥ G means "no spike" (infinity).
- `set_o`  out  1  high for exactly one cycle at phase 0 of each gamma cycle.
- `spike_o`  out  NUM_CH  per-channel temporal-coded output.
- `phase_o`  out  $clog2(G)  current gamma phase, for debug and downstream counters.

## Operation
- State:
  - phase counter `ph`, counting 0..G-1, wraps to 0.
  - `active[NUM_CH]` value register.
  - `pending[NUM_CH]` value register with `pend_v` flag.
- All outputs decode from registered state only. There is no combinational path from any input to any output.
- `in_ready` = `!pend_v`.
- Accept: on `in_valid && in_ready`, `pending` <= `in_value` and `pend_v` <= 1.
- Gamma boundary is the edge where `ph == G-1`. At that edge:
  - If `pend_v`: `active` <= `pending` and `pend_v` <= 0.
  - Otherwise, if accept occurs on this same edge: `in_value` bypasses directly into `active` and `pend_v` stays 0.
  - Otherwise: `active` <= all-infinity, represented as value G.
- `set_o` = (`ph == 0`).
- Pulse mode: `spike_o[i]` = (`ph >= active[i]`) && (`ph - active[i] < P`).
  - Spikes are truncated at the gamma boundary and never spill into the next cycle.
  - Compute the difference at VW bits; no wrap is possible because the `ph >= active[i]` test is done first.
- Values ≥ G leave `spike_o[i]` low for the whole gamma cycle.
- Reset (`grst_n` low at an edge):
  - `ph` <= 0, `active` <= all G, `pend_v` <= 0.
  - `set_o` and `spike_o` are forced to 0 while `grst_n` is low.
  - `in_ready` is 0 during reset and 1 from the first cycle after release.
- Reset mid-gamma discards both `pending` and `active`. The first post-reset cycle is phase 0 with `set_o` = 1 and no spikes.

## Timing
- The input-to-spike latency depends on when the vector is accepted:
  - Accepted during gamma cycle k, or on its last edge: encoded in gamma cycle k+1.
  - Spike appears ph = v cycles after that cycle's `set_o`; `set_o` is at ph 0.
- Value 0 spikes in the same cycle as `set_o`.
- Throughput: one vector per gamma cycle. `in_ready` stays low from accept until the next boundary edge.
- Simultaneous accept and boundary with a pending buffer already full: impossible, because `in_ready` is 0.
- Boundary with `pend_v` = 0 and `in_valid` = 1: bypass into `active`; `in_ready` remains 1 afterwards.

## Configuration
- `SPIKE_ENC_EDGE_CODE_EN`:
  - Defined: rising-edge code. `spike_o[i]` = (`ph >= active[i]`), held until the end of the gamma cycle. `PULSE_WIDTH` is ignored.
  - Undefined: pulse-width code as described above.
- In both modes, infinity values keep the spike low, and `set_o` behaviour is identical.

## Test plan
All scenarios use G=16, P=8, NUM_CH=2.
- Reset:
  - Hold `grst_n` low for 3 cycles, then release → `set_o` = 0 and `spike_o` = 0 during reset.
  - Cycle 1 after release: `set_o` = 1, `phase_o` = 0, `in_ready` = 1.
  - `set_o` repeats every 16 cycles.
- Basic encode: accept {ch1=9, ch0=3} at phase 5 → `in_ready` drops.
  - Next gamma: ch0 is high at phases 3–10, ch1 is high at phases 9–15 (truncated).
  - `in_ready` returns to 1 at phase 0.
- Infinity and zero: values {ch1=16, ch0=0} → ch0 high at phases 0–7, coincident with `set_o`; ch1 stays low all 16 phases.
- Back-pressure and bypass:
  - Second vector offered while `pend_v` = 1 → held; `in_ready` = 0 until the boundary.
  - Vector offered only at phase 15 → bypassed; spikes appear in the immediately following gamma cycle.
- Starvation and mid-cycle reset:
  - No input for one gamma cycle → `spike_o` = 0 throughout.
  - Assert `grst_n` low at phase 7 with active spikes → outputs drop next edge; after release, phase 0 with no spikes and `pend_v` = 0.
- Edge-code build with `SPIKE_ENC_EDGE_CODE_EN`: value 3 → ch0 high from phase 3 through 15, low again at the next phase 0.

Source files
------------

// File: rtl/spike_encoder_if.sv
// rtl/spike_encoder_if.sv - value-vector handshake between a producer and spike_encoder
interface spike_encoder_if #(
    parameter int NUM_CH = 2,
    parameter int VW     = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_CH*VW-1:0] in_value;

    modport master (output in_valid, output in_value, input in_ready);
    modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/spike_encoder.sv
// rtl/spike_encoder.sv - binary-to-race-logic spike encoder with gamma-cycle set pulse
// Optional macro SPIKE_ENC_EDGE_CODE_EN selects held rising-edge code instead of pulse code.
module spike_encoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_CH            = 2,
    localparam int VW = $clog2(GAMMA_CYCLE_WIDTH) + 1,
    localparam int PW = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic              aclk,
    input  logic              grst_n,
    spike_encoder_if.slave    in_if,
    output logic              set_o,
    output logic [NUM_CH-1:0] spike_o,
    output logic [PW-1:0]     phase_o
);
    localparam logic [VW-1:0]        INF     = VW'(GAMMA_CYCLE_WIDTH);
    localparam logic [PW-1:0]        PH_LAST = PW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [NUM_CH*VW-1:0] ALL_INF = {NUM_CH{INF}};

    logic [PW-1:0]        ph;
    logic [NUM_CH*VW-1:0] active;
    logic [NUM_CH*VW-1:0] pending;
    logic                 pend_v;
    logic                 run;
    logic                 accept;
    logic                 boundary;
    logic [VW-1:0]        ph_ext;

    // run holds phase at 0 for one cycle after release so phase 0 is visible with set_o
    assign in_if.in_ready = run && !pend_v;
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign boundary       = (ph == PH_LAST);
    assign ph_ext         = VW'(ph);

    always_ff @(posedge aclk) begin
        if (!grst_n) begin
            ph     <= '0;
            active <= ALL_INF;
            pend_v <= 1'b0;
            run    <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            ph <= boundary ? '0 : ph + 1'b1;
            if (boundary) begin
                if (pend_v) begin
                    active <= pending;
                    pend_v <= 1'b0;
                end else if (accept) begin
                    active <= in_if.in_value;
                end else begin
                    active <= ALL_INF;
                end
            end else if (accept) begin
                pending <= in_if.in_value;
                pend_v  <= 1'b1;
            end
        end
    end

    assign set_o   = run && (ph == '0);
    assign phase_o = ph;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [VW-1:0] val;
        logic          reached;
        assign val     = active[i*VW +: VW];
        assign reached = (ph_ext >= val);
`ifdef SPIKE_ENC_EDGE_CODE_EN
        assign spike_o[i] = run && reached;
`else
        // difference only evaluated once reached is true, so it cannot wrap
        assign spike_o[i] = run && reached && ((ph_ext - val) < VW'(PULSE_WIDTH));
`endif
    end
endmodule

// File: tb/tb_spike_encoder.sv
// tb/tb_spike_encoder.sv - scoreboard bench for spike_encoder against a gamma-cycle reference model
module tb_spike_encoder;
    localparam int G  = 16;
    localparam int P  = 8;
    localparam int NC = 2;
    localparam int VW = 5;
`ifdef SPIKE_ENC_EDGE_CODE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    typedef struct {
        int       cyc;
        bit       set;
        bit [1:0] spk;
        bit [3:0] ph;
        bit       rdy;
    } exp_t;

    logic       aclk = 1'b0;
    logic       grst_n;
    logic       set_o;
    logic [1:0] spike_o;
    logic [3:0] phase_o;

    spike_encoder_if #(.NUM_CH(NC), .VW(VW)) bus ();

    spike_encoder #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH(P),
        .NUM_CH(NC)
    ) dut (
        .aclk(aclk),
        .grst_n(grst_n),
        .in_if(bus.slave),
        .set_o(set_o),
        .spike_o(spike_o),
        .phase_o(phase_o)
    );

    always #5 aclk = ~aclk;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;

    // reference model: cycle index since release, vector per gamma index, ready-low window
    int         c = -2;
    bit         in_rst = 1'b0;
    logic [9:0] gval[int];
    int         hf = -1;
    int         ht = -2;

    function automatic bit m_ready(int cc);
        return !(cc >= hf && cc <= ht);
    endfunction

    function automatic bit [1:0] m_spike(int cc);
        bit [1:0]   r = '0;
        int         k = cc / G;
        int         ph = cc % G;
        logic [9:0] v = gval.exists(k) ? gval[k] : {5'd16, 5'd16};
        for (int ch = 0; ch < NC; ch++) begin
            int vi = int'(v[ch*VW +: VW]);
            if (vi < G && ph >= vi && (EDGE || ph - vi < P)) r[ch] = 1'b1;
        end
        return r;
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge aclk);
        if (!grst_n) begin
            in_rst = 1'b1;
            c = -1;
            gval.delete();
            hf = -1;
            ht = -2;
        end else if (in_rst) begin
            in_rst = 1'b0;
            c = 0;
        end else if (c >= 0) begin
            if (bus.in_valid && m_ready(c)) begin
                gval[c / G + 1] = bus.in_value;
                if (c % G != G - 1) begin
                    hf = c + 1;
                    ht = (c / G) * G + G - 1;
                end
            end
            c++;
        end
        #1;
        if (in_rst) begin
            e = '{cyc: -1, set: 1'b0, spk: 2'b00, ph: 4'd0, rdy: 1'b0};
            sb.push_back(e);
        end else if (c >= 0) begin
            e = '{cyc: c, set: (c % G == 0), spk: m_spike(c), ph: 4'(c % G), rdy: m_ready(c)};
            sb.push_back(e);
        end
    endtask

    task automatic idle_to(int p);
        int guard = 0;
        bus.in_valid = 1'b0;
        tick();
        while ((c < 0 || c % G != p) && guard < 4 * G) begin
            tick();
            guard++;
        end
    endtask

    task automatic offer(logic [4:0] v1, logic [4:0] v0, int hold);
        bus.in_valid = 1'b1;
        bus.in_value = {v1, v0};
        repeat (hold) tick();
        bus.in_valid = 1'b0;
    endtask

    always @(negedge aclk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (set_o !== e.set || spike_o !== e.spk || phase_o !== e.ph || bus.in_ready !== e.rdy) begin
                fails++;
                $display("FAIL cyc%0d: got set=%b spk=%b ph=%0d rdy=%b, want set=%b spk=%b ph=%0d rdy=%b",
                         e.cyc, set_o, spike_o, phase_o, bus.in_ready, e.set, e.spk, e.ph, e.rdy);
            end
        end
    end

    initial begin
        grst_n       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        repeat (3) tick();
        grst_n = 1'b1;
        tick();

        // basic encode at phase 5, then a second vector held against back-pressure
        idle_to(5);
        offer(5'd9, 5'd3, 1);
        idle_to(8);
        offer(5'd12, 5'd5, 10);

        // infinity and zero, then a phase-15 bypass, then a starved gamma
        idle_to(3);
        offer(5'd16, 5'd0, 1);
        idle_to(15);
        idle_to(15);
        offer(5'd7, 5'd2, 1);
        repeat (2 * G + 3) tick();

        // mid-cycle reset with spikes active and a vector pending
        idle_to(4);
        offer(5'd2, 5'd1, 1);
        idle_to(3);
        offer(5'd6, 5'd4, 1);
        idle_to(7);
        grst_n = 1'b0;
        repeat (2) tick();
        grst_n = 1'b1;
        repeat (G + 2) tick();

        // randomized traffic including out-of-range values
        for (int i = 0; i < 600; i++) begin
            bus.in_valid = ($urandom_range(0, 3) == 0);
            bus.in_value = {5'($urandom_range(0, 20)), 5'($urandom_range(0, 20))};
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (G + 1) tick();

        @(negedge aclk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
